// File: rtl/dram_arb_pkg.sv
// Shared types and field positions for the DRAM command arbiter.
// Write control words are {len[7:0], addr[31:0]}, where len is the beat count minus one.
package dram_arb_pkg;

    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_e;

    typedef enum logic [1:0] {IDLE, KICK, RUN} state_e;

    localparam int unsigned WR_LEN_MSB  = 39;
    localparam int unsigned WR_LEN_LSB  = 32;
    localparam int unsigned WR_ADDR_MSB = 31;
    localparam int unsigned WR_WORD_W   = WR_LEN_MSB + 1;

    // len is beats-1, so 255 maps to 256 beats; 32 bits cannot overflow.
    function automatic logic [31:0] wr_beats(input logic [WR_LEN_MSB-WR_LEN_LSB:0] len);
        return {24'b0, len} + 32'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// A pop frees its slot before a push in the same cycle, so push+pop while full is accepted.
module cmd_fifo_sync #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty_q;
    assign do_push = push & (~full_q | do_pop);
    assign drop    = push & ~do_push;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/dram_cmd_arbiter.sv
// Shares the DRAM command port between the HDMI prefetch reader and the UDP frame writer.
// Round-robin arbitration with an urgent-read override bounded by a write anti-starvation guard.
module dram_cmd_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned WR_FIFO_DEPTH  = 4,
    parameter int unsigned MAX_URGENT_RUN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_kick,
    input  logic [31:0]          rd_addr,
    input  logic [31:0]          rd_num,
    input  logic                 rd_urgent,
    output logic                 rd_busy,
    input  logic [WR_WORD_W-1:0] wr_ctrl_in,
    input  logic                 wr_ctrl_we,
    output logic                 wr_ctrl_full,
    output logic                 m_kick,
    input  logic                 m_busy,
    output logic                 m_write,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_num,
    output logic                 wr_drop
);

    localparam int unsigned URG_W = $clog2(MAX_URGENT_RUN + 1);
    localparam logic [URG_W-1:0] URG_MAX = URG_W'(MAX_URGENT_RUN);

    state_e               state_q, state_d;
    grant_e               last_grant_q, last_grant_d;
    logic [URG_W-1:0]     urgent_run_q, urgent_run_d;
    logic                 rd_busy_q, rd_busy_d;
    logic                 m_write_q, m_write_d;
    logic [31:0]          m_addr_q, m_addr_d;
    logic [31:0]          m_num_q, m_num_d;
    logic                 wr_drop_q;

    logic [WR_WORD_W-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_drop;
    logic                 rp, wp, starve_guard;
    logic                 grant_rd, grant_wr, grant_urgent;

    cmd_fifo_sync #(
        .WIDTH(WR_WORD_W),
        .DEPTH(WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (wr_ctrl_we),
        .wdata(wr_ctrl_in),
        .pop  (grant_wr),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .drop (fifo_drop)
    );

    assign rp           = rd_kick & ~rd_busy_q;
    assign wp           = ~fifo_empty;
    assign starve_guard = wp & (urgent_run_q >= URG_MAX);

    always_comb begin
        grant_rd     = 1'b0;
        grant_wr     = 1'b0;
        grant_urgent = 1'b0;
        if (state_q == IDLE) begin
            if (rp & rd_urgent & ~starve_guard) begin
                grant_rd     = 1'b1;
                grant_urgent = 1'b1;
            end else if (rp & wp) begin
                if (last_grant_q == GRANT_WRITE) grant_rd = 1'b1;
                else                             grant_wr = 1'b1;
            end else if (rp) begin
                grant_rd = 1'b1;
            end else if (wp) begin
                grant_wr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_rd | grant_wr) state_d = KICK;
            KICK:    if (m_busy) state_d = RUN;
            RUN:     if (!m_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_kick = 1'b0;
        if (state_q == KICK) m_kick = 1'b1;
    end

    always_comb begin
        m_write_d    = m_write_q;
        m_addr_d     = m_addr_q;
        m_num_d      = m_num_q;
        last_grant_d = last_grant_q;
        urgent_run_d = urgent_run_q;
        rd_busy_d    = rd_busy_q;
        if (grant_rd) begin
            m_write_d    = 1'b0;
            m_addr_d     = rd_addr;
            m_num_d      = rd_num;
            last_grant_d = GRANT_READ;
            rd_busy_d    = 1'b1;
            if (!grant_urgent)                urgent_run_d = '0;
            else if (urgent_run_q != URG_MAX) urgent_run_d = urgent_run_q + 1'b1;
        end else if (grant_wr) begin
            m_write_d    = 1'b1;
            m_addr_d     = fifo_rdata[WR_ADDR_MSB:0];
            m_num_d      = wr_beats(fifo_rdata[WR_LEN_MSB:WR_LEN_LSB]);
            last_grant_d = GRANT_WRITE;
            urgent_run_d = '0;
        end
        if ((state_q == RUN) && !m_busy && !m_write_q) rd_busy_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_num_q      <= '0;
            last_grant_q <= GRANT_WRITE;
            urgent_run_q <= '0;
            rd_busy_q    <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            m_write_q    <= m_write_d;
            m_addr_q     <= m_addr_d;
            m_num_q      <= m_num_d;
            last_grant_q <= last_grant_d;
            urgent_run_q <= urgent_run_d;
            rd_busy_q    <= rd_busy_d;
            wr_drop_q    <= fifo_drop;
        end
    end

    assign rd_busy      = rd_busy_q;
    assign wr_ctrl_full = fifo_full;
    assign m_write      = m_write_q;
    assign m_addr       = m_addr_q;
    assign m_num        = m_num_q;
    assign wr_drop      = wr_drop_q;

endmodule
